// File: rtl/subtractive_divider.sv
// Sequential unsigned divider: subtracts the divisor from the residue once per clock,
// counting subtractions, with a start/busy/done handshake.
module subtractive_divider #(
    parameter int k = 8,
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [k-1:0] X,
    input  logic [m-1:0] Y,
    output logic [k-1:0] Quotient,
    output logic [m-1:0] Remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_next;
    logic [k-1:0] residue, residue_next;
    logic [k-1:0] divisor, divisor_next;
    logic [k-1:0] count, count_next;
    logic [k-1:0] quotient_next;
    logic [m-1:0] remainder_next;
    logic         done_next, dz_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            residue     <= '0;
            divisor     <= '0;
            count       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            residue     <= residue_next;
            divisor     <= divisor_next;
            count       <= count_next;
            Quotient    <= quotient_next;
            Remainder   <= remainder_next;
            done        <= done_next;
            div_by_zero <= dz_next;
        end
    end

    always_comb begin
        state_next     = state;
        residue_next   = residue;
        divisor_next   = divisor;
        count_next     = count;
        quotient_next  = Quotient;
        remainder_next = Remainder;
        dz_next        = div_by_zero;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (Y != '0) begin
                        residue_next = X;
                        divisor_next = k'(Y);
                        count_next   = '0;
                        state_next   = RUN;
                    end else begin
                        // Zero divisor completes immediately with an all-ones quotient.
                        quotient_next  = '1;
                        remainder_next = '0;
                        dz_next        = 1'b1;
                        done_next      = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            RUN: begin
                if (residue >= divisor) begin
                    residue_next = residue - divisor;
                    count_next   = count + 1'b1;
                end else begin
                    // Residue is below the divisor here, so it fits in m bits.
                    quotient_next  = count;
                    remainder_next = residue[m-1:0];
                    dz_next        = 1'b0;
                    done_next      = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
